// File: rtl/caravel_hk_pkg.sv
// Shared constants and the state type for the housekeeping SPI slave.
package caravel_hk_pkg;

  localparam logic [7:0] CMD_RD      = 8'h40;
  localparam logic [7:0] CMD_WR      = 8'h80;
  localparam logic [7:0] CMD_RW      = 8'hC0;
  localparam logic [7:0] CMD_USER_PT = 8'hC2;
  localparam logic [7:0] CMD_MGMT_PT = 8'hC4;

  localparam logic [7:0] ADDR_MFGR_HI  = 8'h01;
  localparam logic [7:0] ADDR_MFGR_LO  = 8'h02;
  localparam logic [7:0] ADDR_PRODUCT  = 8'h03;
  localparam logic [7:0] ADDR_CPU_RST  = 8'h0b;
  localparam logic [7:0] ADDR_SCRATCH0 = 8'h0c;
  localparam logic [7:0] ADDR_SCRATCH1 = 8'h0d;
  localparam logic [7:0] ADDR_SCRATCH2 = 8'h0e;
  localparam logic [7:0] ADDR_SCRATCH3 = 8'h0f;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_PASSTHRU
  } hk_state_e;

endpackage

// File: rtl/caravel_hk_sync.sv
// Two-flop synchronizer with single-cycle rise/fall pulses in the clock domain.
module caravel_hk_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic resetb,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] pipe;

  // pipe[1] is the synchronized level, pipe[2] its previous value for edges
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) pipe <= {3{RST_VAL}};
    else         pipe <= {pipe[1:0], din};
  end

  assign level = pipe[1];
  assign rise  = pipe[1] & ~pipe[2];
  assign fall  = ~pipe[1] & pipe[2];

endmodule

// File: rtl/caravel_hk_spi.sv
// Housekeeping SPI slave: register access (IDs, CPU reset, scratch) and
// flash pass-thru. Define MGMT_PASSTHRU_EN to add the management flash
// pass-thru ports and command 0xC4.
//
// state       | meaning
// ST_IDLE     | CSB high, waiting for CSB fall
// ST_CMD      | shifting in the command byte
// ST_ADDR     | shifting in the stream address byte
// ST_DATA     | streaming data bytes (or dead command)
// ST_PASSTHRU | raw pins forwarded to flash until CSB rises
module caravel_hk_spi
  import caravel_hk_pkg::*;
#(
  parameter logic [7:0]  PRODUCT_ID = 8'h11,
  parameter logic [11:0] MFGR_ID    = 12'h456
) (
  input  logic clock,
  input  logic resetb,
  input  logic spi_csb,
  input  logic spi_sck,
  input  logic spi_sdi,
  output logic spi_sdo,
  output logic spi_sdo_oe,
  output logic user_csb,
  output logic user_sck,
  output logic user_sdo,
  input  logic user_sdi,
`ifdef MGMT_PASSTHRU_EN
  output logic mgmt_csb,
  output logic mgmt_sck,
  output logic mgmt_sdo,
  input  logic mgmt_sdi,
`endif
  output logic cpu_reset
);

  hk_state_e   state, state_nxt;
  logic        sck_q, sck_rise, sck_fall;
  logic        csb_q, csb_rise, csb_fall;
  logic        sdi_meta, sdi_q;
  logic        sck_armed, bit_strobe, in_frame, byte_done, wr_strobe;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [7:0]  byte_in, addr, rd_addr, rd_data, sdo_sr;
  logic        rd_en, wr_en, pt_mgmt, cpu_rst;
  logic [7:0]  scratch [4];
  logic        cmd_rd, cmd_wr, cmd_mgmt, cmd_pt, cmd_stream;
  logic        pt_state, pt_open, user_open, rd_phase;

  caravel_hk_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .clock(clock), .resetb(resetb), .din(spi_sck),
    .level(sck_q), .rise(sck_rise), .fall(sck_fall)
  );

  caravel_hk_sync #(.RST_VAL(1'b1)) u_sync_csb (
    .clock(clock), .resetb(resetb), .din(spi_csb),
    .level(csb_q), .rise(csb_rise), .fall(csb_fall)
  );

  // SDI only needs its level; it is aligned with the synchronized SCK edge
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) {sdi_q, sdi_meta} <= 2'b00;
    else         {sdi_q, sdi_meta} <= {sdi_meta, spi_sdi};
  end

  // Accept a rising SCK only after SCK was seen low (mode 0 idles low)
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb)       sck_armed <= 1'b0;
    else if (csb_fall) sck_armed <= ~sck_q;
    else if (sck_fall) sck_armed <= 1'b1;
    else if (sck_rise) sck_armed <= 1'b0;
  end

  assign bit_strobe = sck_rise & sck_armed & ~csb_q;
  assign in_frame   = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
  assign byte_in    = {shift_in, sdi_q};
  assign byte_done  = bit_strobe & in_frame & (bit_cnt == 3'd7);
  assign wr_strobe  = byte_done & (state == ST_DATA) & wr_en;

  assign cmd_rd     = (byte_in == CMD_RD) || (byte_in == CMD_RW);
  assign cmd_wr     = (byte_in == CMD_WR) || (byte_in == CMD_RW);
  assign cmd_stream = cmd_rd | cmd_wr;
`ifdef MGMT_PASSTHRU_EN
  assign cmd_mgmt   = (byte_in == CMD_MGMT_PT);
`else
  assign cmd_mgmt   = 1'b0;
`endif
  assign cmd_pt     = (byte_in == CMD_USER_PT) | cmd_mgmt;

  // State register
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state; CSB high overrides everything
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (csb_fall) state_nxt = ST_CMD;
      ST_CMD: begin
        if (byte_done) begin
          if (cmd_stream)  state_nxt = ST_ADDR;
          else if (cmd_pt) state_nxt = ST_PASSTHRU;
          else             state_nxt = ST_DATA;
        end
      end
      ST_ADDR: if (byte_done) state_nxt = ST_DATA;
      default: state_nxt = state;
    endcase
    if (csb_q) state_nxt = ST_IDLE;
  end

  // The byte being loaded for output is the addressed one or the next one
  assign rd_addr = (state == ST_ADDR) ? byte_in : addr + 8'd1;

  // Register read mux
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_MFGR_HI:  rd_data = {4'h0, MFGR_ID[11:8]};
      ADDR_MFGR_LO:  rd_data = MFGR_ID[7:0];
      ADDR_PRODUCT:  rd_data = PRODUCT_ID;
      ADDR_CPU_RST:  rd_data = {7'h00, cpu_rst};
      ADDR_SCRATCH0,
      ADDR_SCRATCH1,
      ADDR_SCRATCH2,
      ADDR_SCRATCH3: rd_data = scratch[rd_addr[1:0]];
      default:       rd_data = 8'h00;
    endcase
  end

  // Bit counter, shifters, address pointer and command flags
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      bit_cnt  <= 3'd0;
      shift_in <= 7'd0;
      addr     <= 8'd0;
      sdo_sr   <= 8'd0;
      rd_en    <= 1'b0;
      wr_en    <= 1'b0;
      pt_mgmt  <= 1'b0;
    end else if (csb_rise) begin
      bit_cnt  <= 3'd0;
      shift_in <= 7'd0;
      addr     <= 8'd0;
      sdo_sr   <= 8'd0;
      rd_en    <= 1'b0;
      wr_en    <= 1'b0;
      pt_mgmt  <= 1'b0;
    end else if (bit_strobe && in_frame) begin
      bit_cnt  <= bit_cnt + 3'd1;
      shift_in <= byte_in[6:0];
      if (bit_cnt != 3'd7) begin
        sdo_sr <= {sdo_sr[6:0], 1'b0};
      end else begin
        case (state)
          ST_CMD: begin
            rd_en   <= cmd_rd;
            wr_en   <= cmd_wr;
            pt_mgmt <= cmd_mgmt;
          end
          ST_ADDR: begin
            addr   <= byte_in;
            sdo_sr <= rd_data;
          end
          ST_DATA: begin
            addr   <= addr + 8'd1;
            sdo_sr <= rd_data;
          end
          default: ;
        endcase
      end
    end
  end

  // Writable registers; a partial byte never reaches here
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cpu_rst <= 1'b0;
      for (int i = 0; i < 4; i++) scratch[i] <= 8'h00;
    end else if (wr_strobe) begin
      case (addr)
        ADDR_CPU_RST: cpu_rst <= byte_in[0];
        ADDR_SCRATCH0,
        ADDR_SCRATCH1,
        ADDR_SCRATCH2,
        ADDR_SCRATCH3: scratch[addr[1:0]] <= byte_in;
        default: ;
      endcase
    end
  end

  // Pass-thru gating uses the raw CSB pin so it closes without sync delay
  assign pt_state  = (state == ST_PASSTHRU);
  assign pt_open   = pt_state & ~spi_csb;
  assign user_open = pt_open & ~pt_mgmt;
  assign rd_phase  = (state == ST_DATA) & rd_en;

  assign user_csb   = user_open ? spi_csb : 1'b1;
  assign user_sck   = user_open & spi_sck;
  assign user_sdo   = user_open & spi_sdi;
  assign spi_sdo_oe = pt_open | rd_phase;

`ifdef MGMT_PASSTHRU_EN
  assign mgmt_csb  = (pt_open & pt_mgmt) ? spi_csb : 1'b1;
  assign mgmt_sck  = pt_open & pt_mgmt & spi_sck;
  assign mgmt_sdo  = pt_open & pt_mgmt & spi_sdi;
  assign spi_sdo   = pt_open ? (pt_mgmt ? mgmt_sdi : user_sdi) : (rd_phase & sdo_sr[7]);
  assign cpu_reset = cpu_rst | (pt_state & pt_mgmt);
`else
  assign spi_sdo   = pt_open ? user_sdi : (rd_phase & sdo_sr[7]);
  assign cpu_reset = cpu_rst;
`endif

endmodule

// File: tb/tb_caravel_hk_spi.sv
// Bench for caravel_hk_spi: register map model, flash model, random streams.
module tb_caravel_hk_spi;

  localparam int HALF = 5;

  logic clock = 1'b0, resetb = 1'b0;
  logic spi_csb = 1'b1, spi_sck = 1'b0, spi_sdi = 1'b0, user_sdi = 1'b0;
  logic spi_sdo, spi_sdo_oe, user_csb, user_sck, user_sdo, cpu_reset;

  int total = 0, bad = 0;
  bit pt_exp = 1'b0, pt_pend = 1'b0;
  int csb_settle = 0;

  logic [7:0] mmem  [256];
  logic [7:0] mmask [256];
  logic [7:0] wbuf  [8];
  logic [7:0] rbuf  [8];

  logic [7:0]  fl_mem [8];
  logic [7:0]  exp_fl [8];
  int          fl_rise = 0;
  logic [31:0] fl_cmd = 32'd0;
  logic [23:0] fl_addr = 24'd0;
  bit          fl_low = 1'b0;

  always #5 clock = ~clock;

  caravel_hk_spi dut (
    .clock(clock), .resetb(resetb),
    .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
    .user_csb(user_csb), .user_sck(user_sck), .user_sdo(user_sdo),
    .user_sdi(user_sdi), .cpu_reset(cpu_reset)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 256; i++) begin
      mmem[i] = 8'h00;
      mmask[i] = 8'h00;
    end
    mmem[1] = 8'h04;
    mmem[2] = 8'h56;
    mmem[3] = 8'h11;
    mmask[11] = 8'h01;
    for (int i = 12; i < 16; i++) mmask[i] = 8'hff;
  endtask

  task automatic mdl_write(input logic [7:0] a, input logic [7:0] d);
    mmem[a] = (mmem[a] & ~mmask[a]) | (d & mmask[a]);
  endtask

  // Flash: 32 command/address bits on rising SCK, then data out on falling SCK
  always @(negedge user_csb) begin
    fl_rise = 0;
    fl_cmd = 32'd0;
    fl_low = 1'b0;
  end
  always @(posedge user_csb) fl_low = 1'b0;
  always @(negedge user_sck) begin
    if (!user_csb) begin
      logic [7:0] t;
      int idx;
      fl_low = 1'b1;
      if (fl_rise >= 32) begin
        idx = (int'(fl_addr) + (fl_rise - 32) / 8) % 8;
        t = fl_mem[idx];
        user_sdi = t[7 - ((fl_rise - 32) % 8)];
      end
    end
  end
  always @(posedge user_sck) begin
    if (!user_csb && fl_low) begin
      if (fl_rise < 32) fl_cmd = {fl_cmd[30:0], user_sdo};
      fl_rise++;
      if (fl_rise == 32) fl_addr = fl_cmd[23:0];
    end
  end

  // Per-cycle output checks, sampled 2 time units after the clock edge
  always @(posedge clock) begin
    #2;
    if (spi_csb) csb_settle++;
    else csb_settle = 0;
    if (resetb) begin
      if (csb_settle >= 4)
        check("pins_idle", {26'd0, spi_sdo_oe, spi_sdo, user_csb, user_sck, user_sdo, cpu_reset},
              {26'd0, 5'b00100, mmem[8'h0b][0]});
      if (pt_exp && !spi_csb)
        check("pt_pins", {27'd0, user_csb, user_sck, user_sdo, spi_sdo, spi_sdo_oe},
              {27'd0, 1'b0, spi_sck, spi_sdi, user_sdi, 1'b1});
      if (!pt_pend && !spi_csb)
        check("user_closed", {29'd0, user_csb, user_sck, user_sdo}, {29'd0, 3'b100});
    end
  end

  task automatic xfer(input logic [7:0] tx, input int nbits, input bit exp_oe,
                      input bit chk_rd, input logic [7:0] exp_rd, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_sdi = tx[i];
      repeat (HALF) @(negedge clock);
      rx = {rx[6:0], spi_sdo};
      if (exp_oe) check("sdo_oe", {31'd0, spi_sdo_oe}, 32'd1);
      else        check("sdo_quiet", {30'd0, spi_sdo_oe, spi_sdo}, 32'd0);
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clock);
      spi_sck = 1'b0;
    end
    if (chk_rd) check("rd_byte", {24'd0, rx}, {24'd0, exp_rd});
  endtask

  task automatic cs_start();
    spi_csb = 1'b0;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic cs_end();
    bit was_pt;
    repeat (HALF) @(negedge clock);
    was_pt = pt_exp;
    spi_csb = 1'b1;
    pt_exp = 1'b0;
    pt_pend = 1'b0;
    if (was_pt) begin
      #1;
      check("user_csb_follow", {30'd0, user_csb, user_sck}, {30'd0, 2'b10});
    end
    repeat (2 * HALF) @(negedge clock);
  endtask

  // Command, address, then n data bytes from wbuf; read bytes land in rbuf
  task automatic stream(input logic [7:0] cmd, input logic [7:0] a, input int n, input bit abort_last);
    logic [7:0] rx, ad;
    bit rd, wr, cut;
    rd = (cmd == 8'h40) || (cmd == 8'hC0);
    wr = (cmd == 8'h80) || (cmd == 8'hC0);
    cs_start();
    xfer(cmd, 8, 1'b0, 1'b0, 8'h00, rx);
    xfer(a, 8, 1'b0, 1'b0, 8'h00, rx);
    ad = a;
    for (int k = 0; k < n; k++) begin
      cut = abort_last && (k == n - 1);
      xfer(wbuf[k], cut ? 4 : 8, rd, rd && !cut, mmem[ad], rx);
      rbuf[k] = rx;
      if (!cut) begin
        if (wr) mdl_write(ad, wbuf[k]);
        ad = ad + 8'd1;
      end
    end
    cs_end();
  endtask

  task automatic passthru_read();
    logic [7:0] rx;
    logic [7:0] hdr [4];
    hdr[0] = 8'h03; hdr[1] = 8'h00; hdr[2] = 8'h00; hdr[3] = 8'h00;
    pt_pend = 1'b1;
    cs_start();
    xfer(8'hC2, 8, 1'b0, 1'b0, 8'h00, rx);
    pt_exp = 1'b1;
    check("pt_open", {31'd0, user_csb}, 32'd0);
    for (int k = 0; k < 4; k++) xfer(hdr[k], 8, 1'b1, 1'b0, 8'h00, rx);
    for (int k = 0; k < 8; k++) xfer(8'h00, 8, 1'b1, 1'b1, exp_fl[k], rx);
    check("flash_cmd", fl_cmd, 32'h0300_0000);
    cs_end();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx, cmd, a;
    int n, sel;
    bit abort;

    fl_mem[0] = 8'h6f; fl_mem[1] = 8'h00; fl_mem[2] = 8'h00; fl_mem[3] = 8'h0b;
    fl_mem[4] = 8'h93; fl_mem[5] = 8'h01; fl_mem[6] = 8'h00; fl_mem[7] = 8'h00;
    exp_fl[0] = 8'h6f; exp_fl[1] = 8'h00; exp_fl[2] = 8'h00; exp_fl[3] = 8'h0b;
    exp_fl[4] = 8'h93; exp_fl[5] = 8'h01; exp_fl[6] = 8'h00; exp_fl[7] = 8'h00;
    for (int i = 0; i < 8; i++) wbuf[i] = 8'h00;
    mdl_reset();

    repeat (4) @(negedge clock);
    check("rst_pins", {26'd0, spi_sdo, spi_sdo_oe, user_csb, user_sck, user_sdo, cpu_reset},
          {26'd0, 6'b001000});
    resetb = 1'b1;
    repeat (8) @(negedge clock);

    stream(8'h40, 8'h03, 1, 1'b0);
    check("prod_id", {24'd0, rbuf[0]}, 32'h11);

    stream(8'h40, 8'h01, 3, 1'b0);
    check("id_b0", {24'd0, rbuf[0]}, 32'h04);
    check("id_b1", {24'd0, rbuf[1]}, 32'h56);
    check("id_b2", {24'd0, rbuf[2]}, 32'h11);

    wbuf[0] = 8'h01;
    stream(8'h80, 8'h0b, 1, 1'b0);
    check("cpu_rst_set", {31'd0, cpu_reset}, 32'd1);
    stream(8'h40, 8'h0b, 1, 1'b0);
    check("cpu_rd1", {24'd0, rbuf[0]}, 32'h01);
    wbuf[0] = 8'h00;
    stream(8'h80, 8'h0b, 1, 1'b0);
    check("cpu_rst_clr", {31'd0, cpu_reset}, 32'd0);
    wbuf[0] = 8'hFE;
    stream(8'h80, 8'h0b, 1, 1'b0);
    stream(8'h40, 8'h0b, 1, 1'b0);
    check("cpu_rd_mask", {24'd0, rbuf[0]}, 32'h00);

    passthru_read();

    wbuf[0] = 8'hA5;
    stream(8'h80, 8'h0c, 1, 1'b0);
    wbuf[0] = 8'h5A;
    stream(8'h80, 8'h0c, 1, 1'b1);
    stream(8'h40, 8'h0c, 1, 1'b0);
    check("abort_keep", {24'd0, rbuf[0]}, 32'hA5);

    wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
    stream(8'hC0, 8'h0d, 2, 1'b0);
    check("rw_old0", {24'd0, rbuf[0]}, 32'h00);
    check("rw_old1", {24'd0, rbuf[1]}, 32'h00);
    stream(8'h40, 8'h0d, 2, 1'b0);
    check("rw_new0", {24'd0, rbuf[0]}, 32'h3C);
    check("rw_new1", {24'd0, rbuf[1]}, 32'hC3);

    stream(8'h40, 8'hFF, 3, 1'b0);
    check("wrap_ff", {24'd0, rbuf[0]}, 32'h00);
    check("wrap_00", {24'd0, rbuf[1]}, 32'h00);
    check("wrap_01", {24'd0, rbuf[2]}, 32'h04);

    for (int t = 0; t < 24; t++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1:    cmd = 8'h40;
        2:       cmd = 8'h80;
        3:       cmd = 8'hC0;
        4:       cmd = 8'h80;
        default: begin
          cmd = 8'($urandom);
          while (cmd == 8'h40 || cmd == 8'h80 || cmd == 8'hC0 || cmd == 8'hC2) cmd = 8'($urandom);
        end
      endcase
      case ($urandom_range(0, 3))
        0:       a = 8'($urandom_range(0, 16));
        1:       a = 8'($urandom_range(253, 255));
        2:       a = 8'($urandom_range(11, 15));
        default: a = 8'($urandom);
      endcase
      if (sel == 4) a = 8'h0b;
      n = $urandom_range(1, 4);
      for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
      abort = (cmd == 8'h80 || cmd == 8'hC0) && ($urandom_range(0, 4) == 0);
      stream(cmd, a, n, abort);
    end

    pt_pend = 1'b1;
    cs_start();
    xfer(8'hC2, 8, 1'b0, 1'b0, 8'h00, rx);
    pt_exp = 1'b1;
    xfer(8'h03, 8, 1'b1, 1'b0, 8'h00, rx);
    resetb = 1'b0;
    pt_exp = 1'b0;
    mdl_reset();
    #1;
    check("rst_mid_pt", {29'd0, user_csb, spi_sdo_oe, cpu_reset}, {29'd0, 3'b100});
    repeat (3) @(negedge clock);
    spi_csb = 1'b1;
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    pt_pend = 1'b0;
    repeat (8) @(negedge clock);
    stream(8'h40, 8'h03, 1, 1'b0);
    check("prod_after_rst", {24'd0, rbuf[0]}, 32'h11);

    repeat (10) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/caravel_hk_spi.md
# caravel_hk_spi

Housekeeping SPI slave for the caravel padframe. Gives an external host register-level access to chip identity and CPU reset control over a 4-wire SPI on mprj_io[4:1], and forwards whole SPI transactions to the user-area flash (mprj_io[11:8]) in pass-thru mode. Sits between the housekeeping pads and the management core reset.

## Interface
- PRODUCT_ID, 8'h11, value returned at register 0x03.
- MFGR_ID, 12'h456, manufacturer ID; reg 0x01 = {4'h0, MFGR_ID[11:8]}, reg 0x02 = MFGR_ID[7:0].

Ports:
- clock  in  1  system clock; all logic synchronous to it.
- resetb  in  1  reset; asynchronous, active-low.
- spi_csb  in  1  host chip select, active-low.
- spi_sck  in  1  host SPI clock, mode 0.
- spi_sdi  in  1  host data in.
- spi_sdo  out  1  host data out.
- spi_sdo_oe  out  1  high while spi_sdo is driven (read data phase or pass-thru).
- user_csb  out  1  user flash chip select.
- user_sck  out  1  user flash clock.
- user_sdo  out  1  to flash io0.
- user_sdi  in  1  from flash io1.
- cpu_reset  out  1  active-high management CPU reset.

## Operation
- spi_csb, spi_sck, spi_sdi pass through 2-FF synchronizers to clock. Edges are detected in the clock domain. SCK half-period must be at least 4 clock periods.
- States: IDLE, CMD, ADDR, DATA, PASSTHRU. spi_csb high forces IDLE from any state, and bit counter and shift registers clear. Falling CSB enters CMD.
- Bits are sampled MSB first on SCK rising edges. Each byte completes on its 8th rising edge.
- Command byte:
  - 0x40: stream read.
  - 0x80: stream write.
  - 0xC0: stream read+write.
  - 0xC2: user pass-thru.
  - Anything else: go to DATA with read and write both disabled. No effect, spi_sdo=0, oe=0.
- Stream commands: the next byte is an 8-bit address, then DATA.
  - Read: on address completion, load reg[addr] and drive bit 7. After each subsequent rising edge, drive the next bit.
  - Write: reg[addr] is written when the 8th bit of a data byte completes.
  - The address increments after each data byte and wraps 0xFF→0x00. Read+write reads the old value.
- Register map:
  - 0x01/0x02: manufacturer ID, read-only.
  - 0x03: PRODUCT_ID, read-only.
  - 0x0b: bit0 drives cpu_reset. Read/write; other bits read 0.
  - 0x0c–0x0f: 8-bit scratch, read/write.
  - All other addresses read 0x00; writes to them are ignored.
- PASSTHRU is entered on completion of 0xC2 and lasts until spi_csb rises. While active, outputs are combinational from raw pins:
  - user_csb = spi_csb
  - user_sck = spi_sck
  - user_sdo = spi_sdi
  - spi_sdo = user_sdi
  - spi_sdo_oe = 1
- Outside PASSTHRU: user_csb=1, user_sck=0, user_sdo=0.

## Timing
- Reset values:
  - spi_sdo=0, spi_sdo_oe=0.
  - user_csb=1, user_sck=0, user_sdo=0.
  - cpu_reset=0.
  - Writable registers 0, state IDLE.
- spi_sdo changes at most 3 clocks after the synchronized SCK rising edge. The host samples before the next rising edge.
- Register write takes effect, and cpu_reset updates, 1 clock after byte completion (≤4 clocks after the SCK rise).
- Pass-thru gating opens within 3 clocks of the command's 8th rising edge. It closes the same instant spi_csb rises (raw pin, no synchronizer delay).
- CSB rising mid-byte: the partial byte is discarded and there is no write.
- resetb mid-transaction: immediate return to reset values.

## Configuration
- MGMT_PASSTHRU_EN defined: adds ports mgmt_csb, mgmt_sck, mgmt_sdo (out) and mgmt_sdi (in), and command 0xC4.
  - 0xC4 forwards to the management flash exactly as 0xC2 does to the user flash.
  - cpu_reset is held high for the duration of 0xC4 pass-thru.
- MGMT_PASSTHRU_EN undefined: those ports do not exist and 0xC4 is an unrecognized command.

## Structure
- Shared package caravel_hk_pkg holds:
  - command constants (CMD_RD=8'h40, CMD_WR=8'h80, CMD_RW=8'hC0, CMD_USER_PT=8'hC2, CMD_MGMT_PT=8'hC4);
  - register address constants;
  - the state enum.
- One sub-module, caravel_hk_sync: a 2-FF synchronizer with rise/fall pulse outputs, instantiated for SCK and CSB; SDI uses its synchronized level only.

## Test plan
- After reset: 0x40, 0x03, one read byte → 0x11. cpu_reset=0 and user_csb=1 throughout.
- 0x40, 0x01 streaming 3 bytes → 0x04, 0x56, 0x11 (auto-increment).
- 0x80, 0x0b, 0x01 → cpu_reset=1. 0x80, 0x0b, 0x00 → cpu_reset=0. A read of 0x0b returns the current value.
- 0xC2 then 0x03 00 00 00 to a flash model preloaded with 6f 00 00 0b 93 01 00 00 → host reads those 8 bytes in order. user_csb rises with spi_csb.
- Write 0xA5 to 0x0c, then raise CSB after 4 bits of a second write of 0x5A → reg 0x0c still reads 0xA5.
- Assert resetb mid pass-thru → user_csb=1, spi_sdo_oe=0 immediately. Next 0x40/0x03 read returns 0x11.
